// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: the bundle that connects NUM_CH requestors and one
// synchronous RAM port to the memory arbiter.
//
// Requestor side (one lane per channel, packed channel i at [i*W +: W]):
//   req, we, addr, wdata  -> arbiter
//   gnt, rdata, rvalid    <- arbiter
// RAM side:
//   mem_en, mem_we, mem_addr, mem_wdata <- arbiter
//   mem_rdata                           -> arbiter
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requestors plus the RAM)
interface mem_arbiter_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        we;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*DATA_W-1:0] wdata;
  logic [NUM_CH-1:0]        gnt;
  logic [DATA_W-1:0]        rdata;
  logic [NUM_CH-1:0]        rvalid;
  logic                     mem_en;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, rdata, rvalid, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, rdata, rvalid, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel arbiter in front of a single synchronous RAM port.
//
// The arbiter picks one requesting channel per cycle. It uses round-robin
// selection, and channel 0 can optionally take absolute priority. The
// winning command is registered onto the RAM port. Each read carries a tag
// through a pipeline, so the returned data goes back to the channel that
// issued the read.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      mem_arbiter_if.slave (requestor lanes + RAM port)
//
// Timing for a grant in cycle t:
//   gnt            cycle t        (combinational)
//   mem_en/cmd     cycle t+1
//   mem_rdata      cycle t+1+RD_LAT
//   rvalid/rdata   cycle t+2+RD_LAT
module mem_arbiter #(
  parameter int NUM_CH   = 3,
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int PRIO_CH0 = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              gnt_rr;
  logic [NUM_CH-1:0] gnt_vec;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [NUM_CH-1:0] rvalid_q;

  // Read tags. Stage 0 is loaded together with the RAM command.
  // Stage RD_LAT lines up with the cycle in which mem_rdata is valid.
  logic              tag_v  [RD_LAT+1];
  logic [IDX_W-1:0]  tag_id [RD_LAT+1];

  // Grant selection. The search starts just after the last round-robin
  // winner. cand is always reduced modulo NUM_CH, so unused req bit
  // positions are never looked at. When channel 0 has priority, it never
  // takes part in the rotation.
  always_comb begin
    gnt_vec = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    gnt_rr  = 1'b0;
    cand    = '0;
    if (PRIO_CH0 != 0 && bus.req[0]) begin
      gnt_any = 1'b1;
    end else begin
      for (int j = 1; j <= NUM_CH; j++) begin
        cand = IDX_W'((int'(last) + j) % NUM_CH);
        if (!gnt_any && bus.req[cand] && !(PRIO_CH0 != 0 && cand == '0)) begin
          gnt_any = 1'b1;
          gnt_rr  = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_any) begin
      gnt_vec[gnt_idx] = 1'b1;
    end
  end

  // Mux the granted channel's command.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_vec[i]) begin
        sel_we    = bus.we[i];
        sel_addr  = bus.addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Update the round-robin pointer and the registered command stage.
  // Address and write data hold their values on idle cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last        <= IDX_W'(NUM_CH - 1);
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (gnt_rr) begin
        last <= gnt_idx;
      end
      mem_en_q <= gnt_any;
      mem_we_q <= gnt_any & sel_we;
      if (gnt_any) begin
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
    end
  end

  // Tag pipeline and read return. Reset clears every tag, so reads that
  // were in flight produce no rvalid after reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_v[i]  <= 1'b0;
        tag_id[i] <= '0;
      end
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      tag_v[0]  <= gnt_any & ~sel_we;
      tag_id[0] <= gnt_idx;
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      if (tag_v[RD_LAT]) begin
        rdata_q  <= bus.mem_rdata;
        rvalid_q <= NUM_CH'(1) << tag_id[RD_LAT];
      end else begin
        rvalid_q <= '0;
      end
    end
  end

  assign bus.gnt       = gnt_vec;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
endmodule
